// File: rtl/gauss3x3_if.sv
// Pixel stream bundle for the 3x3 window filter: three aligned input rows in,
// one filtered pixel with border/end-of-frame flags out.
interface gauss3x3_if #(
    parameter int unsigned W = 24
);
    logic         sof;
    logic         valid_in;
    logic [1:0]   mode;
    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic [W-1:0] din3;
    logic [W-1:0] dout;
    logic         valid_out;
    logic         border_out;
    logic         eof_out;

    modport master (
        output sof, valid_in, mode, din1, din2, din3,
        input  dout, valid_out, border_out, eof_out
    );

    modport slave (
        input  sof, valid_in, mode, din1, din2, din3,
        output dout, valid_out, border_out, eof_out
    );
endinterface

// File: rtl/gauss3x3_filter.sv
// 3x3 Gaussian / cross / bypass filter over a multi-channel pixel stream,
// with column/row tracking for border and end-of-frame flags.
module gauss3x3_filter #(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned CH_WIDTH    = 8,
    parameter int unsigned PIC_WIDTH   = 640,
    parameter int unsigned PIC_HEIGHT  = 480,
    parameter bit          BORDER_ZERO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    gauss3x3_if.slave bus
);
    localparam int unsigned W     = CHANNELS * CH_WIDTH;
    localparam int unsigned ACC   = CH_WIDTH + 4;
    localparam int unsigned COL_W = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int unsigned ROW_W = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;

    // tap_q[row][tap]: row 0..2 = din1..din3, tap 0 newest, tap 2 oldest
    logic [W-1:0]     tap_q [3][3];
    logic [COL_W-1:0] col_q, col_d, cur_col_c;
    logic [ROW_W-1:0] row_q, row_d, cur_row_c;
    logic [1:0]       mode_q, mode_d;
    logic             border0_q, border0_d, eof0_q, eof0_d, v0_q;

    logic [W-1:0]     centre_q;
    logic [1:0]       modea_q;
    logic             bordera_q, eofa_q, va_q;

    logic [W-1:0]     dout_q, dout_d;
    logic             valid_q, border_q, eof_q;

    // Position of the current beat (sof forces 0,0) and the position of the next one
    always_comb begin
        cur_col_c = bus.sof ? '0 : col_q;
        cur_row_c = bus.sof ? '0 : row_q;
        col_d     = col_q;
        row_d     = row_q;
        if (cur_col_c == COL_W'(PIC_WIDTH - 1)) begin
            col_d = '0;
            row_d = (cur_row_c == ROW_W'(PIC_HEIGHT - 1)) ? '0 : cur_row_c + ROW_W'(1);
        end else begin
            col_d = cur_col_c + COL_W'(1);
            row_d = cur_row_c;
        end
        mode_d    = bus.sof ? bus.mode : mode_q;
        border0_d = (cur_col_c < COL_W'(2)) || (cur_row_c < ROW_W'(2));
        eof0_d    = (cur_col_c == COL_W'(PIC_WIDTH - 1)) && (cur_row_c == ROW_W'(PIC_HEIGHT - 1));
    end

    // Window shift, counters and per-beat flags; everything holds through gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q     <= '{default: '0};
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= '0;
            border0_q <= 1'b0;
            eof0_q    <= 1'b0;
            v0_q      <= 1'b0;
        end else begin
            v0_q <= bus.valid_in;
            if (bus.valid_in) begin
                tap_q[0][0] <= bus.din1;
                tap_q[1][0] <= bus.din2;
                tap_q[2][0] <= bus.din3;
                tap_q[0][1] <= tap_q[0][0];
                tap_q[1][1] <= tap_q[1][0];
                tap_q[2][1] <= tap_q[2][0];
                tap_q[0][2] <= tap_q[0][1];
                tap_q[1][2] <= tap_q[1][1];
                tap_q[2][2] <= tap_q[2][1];
                col_q       <= col_d;
                row_q       <= row_d;
                mode_q      <= mode_d;
                border0_q   <= border0_d;
                eof0_q      <= eof0_d;
            end
        end
    end

    // mode_q only changes on sof beats, so it is always the mode of the newest beat
    always_ff @(posedge clk) begin
        if (rst) begin
            centre_q  <= '0;
            modea_q   <= '0;
            bordera_q <= 1'b0;
            eofa_q    <= 1'b0;
            va_q      <= 1'b0;
        end else begin
            centre_q  <= tap_q[1][1];
            modea_q   <= mode_q;
            bordera_q <= border0_q;
            eofa_q    <= eof0_q;
            va_q      <= v0_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam int unsigned LSB = c * CH_WIDTH;

        logic [ACC-1:0]      p [3][3];
        logic [ACC-1:0]      gauss_c, cross_c, sum_d, sum_q;
        logic [CH_WIDTH-1:0] res_c;

        for (genvar r = 0; r < 3; r++) begin : g_r
            for (genvar t = 0; t < 3; t++) begin : g_t
                assign p[r][t] = ACC'(tap_q[r][t][LSB +: CH_WIDTH]);
            end
        end

        // Rounding constant folded into the sum; max 16*(2^CH_WIDTH-1)+8 fits ACC bits
        always_comb begin
            gauss_c = p[0][0] + (p[0][1] << 1) + p[0][2]
                    + (p[1][0] << 1) + (p[1][1] << 2) + (p[1][2] << 1)
                    + p[2][0] + (p[2][1] << 1) + p[2][2] + ACC'(8);
            cross_c = p[0][1] + p[1][0] + (p[1][1] << 2) + p[1][2] + p[2][1] + ACC'(4);
            sum_d   = (mode_q == 2'd0) ? gauss_c : cross_c;
        end

        always_ff @(posedge clk) begin
            if (rst) sum_q <= '0;
            else     sum_q <= sum_d;
        end

        always_comb begin
            res_c = centre_q[LSB +: CH_WIDTH];
            if (bordera_q) begin
                res_c = BORDER_ZERO ? '0 : centre_q[LSB +: CH_WIDTH];
            end else if (modea_q == 2'd0) begin
                res_c = CH_WIDTH'(sum_q >> 4);
            end else if (modea_q == 2'd1) begin
                res_c = CH_WIDTH'(sum_q >> 3);
            end
        end

        assign dout_d[LSB +: CH_WIDTH] = res_c;
    end

    // Output stage: loads only on a valid beat so values hold through gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q   <= '0;
            valid_q  <= 1'b0;
            border_q <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            valid_q <= va_q;
            if (va_q) begin
                dout_q   <= dout_d;
                border_q <= bordera_q;
                eof_q    <= eofa_q;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.valid_out  = valid_q;
    assign bus.border_out = border_q;
    assign bus.eof_out    = eof_q;
endmodule
